rv_mc_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32I R-type execution datapath. It fetches instructions over a simple request/acknowledge port and decodes opcode/funct3/funct7 into ALU and register-file controls. It sequences decode, execute and writeback, and maintains the PC and a retired-instruction counter. It sits between instruction memory and the register file/ALU pair.

---
 rtl/rv_ctrl_pkg.sv | 31 +++
 rtl/rv_rtype_decode.sv | 43 ++++
 rtl/rv_mc_sequencer.sv | 140 ++++++++++++++
 tb/tb_rv_mc_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I R-type multi-cycle sequencer: ALU selects,
// opcode/funct7 constants, FSM states and fault causes.
package rv_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_FAULT
    } state_e;

endpackage

// File: rtl/rv_rtype_decode.sv
// Combinational R-type decoder: maps opcode/funct3/funct7 to an ALU select
// and flags anything outside the supported subset as illegal.
module rv_rtype_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_ctrl,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        if (opcode == OP_RTYPE) begin
            if (funct7 == F7_BASE) begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_ctrl = ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    // SLTU is not supported by this datapath
                    default: legal = 1'b0;
                endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                alu_ctrl = ALU_SUB;
                legal    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I R-type sequencer: FETCH -> DECODE -> EXEC -> WB, with PC,
// retired-instruction counter, fetch timeout and sticky fault handling.
module rv_mc_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [3:0]  alu_ctrl,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        stop_q, stop_d;
    logic [1:0]  fcode_q, fcode_d;

    logic [3:0]  dec_alu;
    logic        dec_legal;

    rv_rtype_decode u_decode (
        .ir       (ir_q),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
            tcnt_q    <= '0;
            stop_q    <= 1'b0;
            fcode_q   <= FC_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            tcnt_q    <= tcnt_d;
            stop_q    <= stop_d;
            fcode_q   <= fcode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        tcnt_d    = tcnt_q;
        stop_d    = stop_q;
        fcode_d   = fcode_q;
        case (state_q)
            S_IDLE: begin
                // a simultaneous stop_req limits the run to one instruction
                if (start) begin
                    state_d = S_FETCH;
                    tcnt_d  = '0;
                    stop_d  = stop_req;
                end
            end
            S_FETCH: begin
                stop_d = stop_q | stop_req;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (tcnt_q + 8'd1 == FETCH_TIMEOUT) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                stop_d = stop_q | stop_req;
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                    fcode_d = FC_ILLEGAL;
                end
            end
            S_EXEC: begin
                stop_d  = stop_q | stop_req;
                state_d = S_WB;
            end
            S_WB: begin
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                if (stop_q || stop_req) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b0;
                end else begin
                    state_d = S_FETCH;
                    tcnt_d  = '0;
                end
            end
            S_FAULT: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == S_FETCH);
        imem_addr  = pc_q;
        rs1_addr   = ir_q[19:15];
        rs2_addr   = ir_q[24:20];
        rd_addr    = ir_q[11:7];
        alu_ctrl   = ((state_q == S_EXEC) || (state_q == S_WB)) ? dec_alu : ALU_ADD;
        rf_we      = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
        pc         = pc_q;
        instret    = instret_q;
        busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
        fault      = (state_q == S_FAULT);
        fault_code = fcode_q;
    end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed bench for rv_mc_sequencer with hand-computed expectations.
module tb_rv_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_ctrl;
    logic        rf_we;
    logic [31:0] pc, instret;
    logic        busy, fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_ADD0 = 32'h00208033;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;

    rv_mc_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(8'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop_req   (stop_req),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .alu_ctrl   (alu_ctrl),
        .rf_we      (rf_we),
        .pc         (pc),
        .instret    (instret),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; stop_req = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Waits (bounded) for a fetch, stalls 'waits' cycles, then acks with instr.
    task automatic serve_fetch(input logic [31:0] instr, input int waits,
                               input logic [31:0] exp_addr, output bit ok);
        int guard = 0;
        ok = 1'b1;
        while (imem_req !== 1'b1 && guard < 20) begin
            tick;
            guard++;
        end
        if (imem_req !== 1'b1) ok = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) ok = 1'b0;
            tick;
        end
        if (imem_req !== 1'b1 || imem_addr !== exp_addr) ok = 1'b0;
        imem_ack = 1'b1; imem_rdata = instr;
        tick;
        imem_ack = 1'b0; imem_rdata = '0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'd0); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
        checks++; if ({busy, fault, fault_code, imem_req, rf_we} !== 6'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 000000", {busy, fault, fault_code, imem_req, rf_we}); end
        checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL reset_alu got %b exp 0010", alu_ctrl); end
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignores_stop got busy=%b exp 0", busy); end
    endtask

    task automatic test_zero_wait_add;
        bit ok;
        do_reset;
        pulse_start;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || busy !== 1'b1) begin errors++;
            $display("FAIL add_fetch got req=%b addr=%h busy=%b exp 1 0 1", imem_req, imem_addr, busy); end
        serve_fetch(I_ADD, 0, 32'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_serve got ok=0 exp 1"); end
        checks++; if ({rs1_addr, rs2_addr, rd_addr} !== {5'd1, 5'd2, 5'd3}) begin errors++;
            $display("FAIL add_regs got %0d %0d %0d exp 1 2 3", rs1_addr, rs2_addr, rd_addr); end
        tick;
        checks++; if (alu_ctrl !== 4'b0010 || rf_we !== 1'b0) begin errors++;
            $display("FAIL add_exec got alu=%b we=%b exp 0010 0", alu_ctrl, rf_we); end
        tick;
        checks++; if (rf_we !== 1'b1 || rd_addr !== 5'd3 || alu_ctrl !== 4'b0010) begin errors++;
            $display("FAIL add_wb got we=%b rd=%0d alu=%b exp 1 3 0010", rf_we, rd_addr, alu_ctrl); end
        tick;
        checks++; if (pc !== 32'd4 || instret !== 32'd1 || rf_we !== 1'b0) begin errors++;
            $display("FAIL add_retire got pc=%h instret=%0d we=%b exp 4 1 0", pc, instret, rf_we); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++;
            $display("FAIL add_next_fetch got req=%b addr=%h exp 1 4", imem_req, imem_addr); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        do_reset;
        pulse_start;
        serve_fetch(I_SUB, 2, 32'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_sub_fetch addr unstable or no req"); end
        tick;
        checks++; if (alu_ctrl !== 4'b0100) begin errors++; $display("FAIL b2b_sub_alu got %b exp 0100", alu_ctrl); end
        tick;
        tick;
        serve_fetch(I_AND, 2, 32'd4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_and_fetch addr unstable or no req"); end
        tick;
        checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL b2b_and_alu got %b exp 0000", alu_ctrl); end
        tick;
        tick;
        checks++; if (pc !== 32'd8 || instret !== 32'd2) begin errors++;
            $display("FAIL b2b_retire got pc=%h instret=%0d exp 8 2", pc, instret); end
        checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL b2b_alu_revert got %b exp 0010", alu_ctrl); end
    endtask

    task automatic test_x0_write;
        bit ok;
        do_reset;
        pulse_start;
        serve_fetch(I_ADD0, 0, 32'd0, ok);
        tick;
        tick;
        checks++; if (rf_we !== 1'b0 || rd_addr !== 5'd0) begin errors++;
            $display("FAIL x0_we got we=%b rd=%0d exp 0 0", rf_we, rd_addr); end
        tick;
        checks++; if (pc !== 32'd4 || instret !== 32'd1) begin errors++;
            $display("FAIL x0_retire got pc=%h instret=%0d exp 4 1", pc, instret); end
    endtask

    task automatic test_illegal;
        bit ok;
        do_reset;
        pulse_start;
        serve_fetch(I_SLTU, 0, 32'd0, ok);
        tick;
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01 || pc !== 32'd0 || busy !== 1'b0) begin errors++;
            $display("FAIL sltu_fault got f=%b code=%b pc=%h busy=%b exp 1 01 0 0", fault, fault_code, pc, busy); end
        pulse_start;
        tick;
        checks++; if (fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0 || instret !== 32'd0) begin errors++;
            $display("FAIL fault_sticky got f=%b req=%b busy=%b instret=%0d exp 1 0 0 0", fault, imem_req, busy, instret); end
        do_reset;
        checks++; if (fault !== 1'b0 || fault_code !== 2'b00) begin errors++;
            $display("FAIL fault_clear got f=%b code=%b exp 0 00", fault, fault_code); end
        pulse_start;
        serve_fetch(I_SRA, 0, 32'd0, ok);
        tick;
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin errors++;
            $display("FAIL sra_fault got f=%b code=%b exp 1 01", fault, fault_code); end
    endtask

    task automatic test_timeout;
        bit ok;
        do_reset;
        pulse_start;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || fault !== 1'b0) begin errors++;
                $display("FAIL timeout_wait%0d got req=%b f=%b exp 1 0", i, imem_req, fault); end
            tick;
        end
        checks++; if (fault !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0) begin errors++;
            $display("FAIL timeout_fault got f=%b code=%b req=%b exp 1 10 0", fault, fault_code, imem_req); end
        do_reset;
        pulse_start;
        serve_fetch(I_ADD, 3, 32'd0, ok);
        checks++; if (!ok || fault !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL ack_at_limit got ok=%b f=%b busy=%b exp 1 0 1", ok, fault, busy); end
    endtask

    task automatic test_stop;
        bit ok;
        do_reset;
        pulse_start;
        serve_fetch(I_ADD, 0, 32'd0, ok);
        tick;
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL stop_exec_wb got we=%b exp 1", rf_we); end
        tick;
        checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 32'd4 || instret !== 32'd1) begin errors++;
            $display("FAIL stop_exec_idle got busy=%b req=%b pc=%h instret=%0d exp 0 0 4 1", busy, imem_req, pc, instret); end
        tick;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_stays_idle got busy=%b exp 0", busy); end
        pulse_start;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++;
            $display("FAIL stop_resume got req=%b addr=%h exp 1 4", imem_req, imem_addr); end
        serve_fetch(I_ADD, 0, 32'd4, ok);
        tick;
        tick;
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        checks++; if (busy !== 1'b0 || pc !== 32'd8 || instret !== 32'd2) begin errors++;
            $display("FAIL stop_in_wb got busy=%b pc=%h instret=%0d exp 0 8 2", busy, pc, instret); end
    endtask

    task automatic test_start_and_stop;
        bit ok;
        do_reset;
        start = 1'b1; stop_req = 1'b1;
        tick;
        start = 1'b0; stop_req = 1'b0;
        serve_fetch(I_AND, 0, 32'd0, ok);
        tick;
        tick;
        tick;
        checks++; if (busy !== 1'b0 || instret !== 32'd1 || pc !== 32'd4) begin errors++;
            $display("FAIL start_stop_one got busy=%b instret=%0d pc=%h exp 0 1 4", busy, instret, pc); end
    endtask

    task automatic test_async_reset;
        bit ok;
        do_reset;
        pulse_start;
        serve_fetch(I_ADD, 0, 32'd0, ok);
        tick;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'd0 || instret !== 32'd0) begin errors++;
            $display("FAIL async_reset got req=%b busy=%b pc=%h instret=%0d exp 0 0 0 0", imem_req, busy, pc, instret); end
        #3;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop_req = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        test_reset;
        test_zero_wait_add;
        test_back_to_back;
        test_x0_write;
        test_illegal;
        test_timeout;
        test_stop;
        test_start_and_stop;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
